// File: rtl/cache_profile_reporter.sv
// Periodic cache-profiler readout: snapshots all counters every INTERVAL_CYCLES
// and streams them as a framed, checksummed byte sequence over valid/ready.
module cache_profile_reporter #(
  parameter int unsigned NUM_COUNTERS    = 8,
  parameter int unsigned INTERVAL_CYCLES = 2000000,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [32*NUM_COUNTERS-1:0]  counters,
  output logic                        prof_enable,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic [7:0]                  seq_num,
  output logic                        overrun
);

  localparam int unsigned NUM_BYTES = 4 * NUM_COUNTERS;
  localparam int unsigned SNAP_W    = 32 * NUM_COUNTERS;
  localparam int unsigned IDX_W     = $clog2(NUM_BYTES);
  localparam int unsigned CNT_W     = $clog2(INTERVAL_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INTERVAL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    CAPTURE,
    SEND_SYNC,
    SEND_SEQ,
    SEND_DATA,
    SEND_CSUM
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   icnt_q, icnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         seq_q, seq_d;
  logic               ovr_q, ovr_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic [7:0]         txd_q, txd_d;
  logic               txv_q, txv_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;

  logic               hs;
  logic               expire;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W-1:0]   nxt_sel;
  logic [IDX_W+2:0]   nxt_off;
  logic [7:0]         next_byte;

  // Byte i of the frame payload is counter i/4, MSB first: flipping the two
  // low index bits turns byte order into little-endian bit position.
  assign hs        = txv_q & tx_ready;
  assign expire    = (icnt_q == LAST_CNT);
  assign idx_nxt   = idx_q + IDX_W'(1);
  assign nxt_sel   = (state_q == SEND_SEQ) ? '0 : idx_nxt;
  assign nxt_off   = {nxt_sel ^ IDX_W'(3), 3'b000};
  assign next_byte = snap_q[nxt_off +: 8];

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    en_d    = run;
    busy_d  = busy_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    snap_d  = snap_q;

    // Interval keeps ticking through transmission so snapshots stay periodic
    if (state_q != IDLE) begin
      icnt_d = expire ? '0 : icnt_q + CNT_W'(1);
    end
    if (busy_q && expire) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = COUNT;
          icnt_d  = '0;
        end
      end
      COUNT: begin
        if (!run) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d = CAPTURE;
          busy_d  = 1'b1;
          seq_d   = seq_q + 8'd1;
          snap_d  = counters;
        end
      end
      CAPTURE: begin
        csum_d  = 8'd0;
        state_d = SEND_SYNC;
        txv_d   = 1'b1;
        txd_d   = SYNC_BYTE;
      end
      SEND_SYNC: begin
        if (hs) begin
          state_d = SEND_SEQ;
          txd_d   = seq_q;
          csum_d  = seq_q;
        end
      end
      SEND_SEQ: begin
        if (hs) begin
          state_d = SEND_DATA;
          idx_d   = '0;
          txd_d   = next_byte;
          csum_d  = csum_q + next_byte;
        end
      end
      SEND_DATA: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = SEND_CSUM;
            txd_d   = csum_q;
          end else begin
            idx_d  = idx_nxt;
            txd_d  = next_byte;
            csum_d = csum_q + next_byte;
          end
        end
      end
      SEND_CSUM: begin
        if (hs) begin
          txv_d   = 1'b0;
          txd_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = run ? COUNT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      icnt_q  <= '0;
      idx_q   <= '0;
      csum_q  <= 8'd0;
      seq_q   <= 8'd0;
      ovr_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      txd_q   <= 8'd0;
      txv_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      snap_q  <= snap_d;
    end
  end

  assign prof_enable = en_q;
  assign tx_data     = txd_q;
  assign tx_valid    = txv_q;
  assign busy        = busy_q;
  assign seq_num     = seq_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_cache_profile_reporter.sv
// Self-checking bench for cache_profile_reporter: frame-level reference model
// (whole frame built as a byte queue at each snapshot) checked every cycle.
module tb_cache_profile_reporter;

  localparam int unsigned N    = 8;
  localparam int unsigned IV   = 40;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned FLEN = 4 * N + 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           run;
  logic           tx_ready;
  logic [32*N-1:0] counters;
  logic           prof_enable;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           busy;
  logic [7:0]     seq_num;
  logic           overrun;

  int total = 0;
  int bad   = 0;

  int   rdy_mode = 0;
  bit   rand_cnt = 1'b0;
  int   phase    = 0;
  logic [7:0] rx[$];

  cache_profile_reporter #(
    .NUM_COUNTERS   (N),
    .INTERVAL_CYCLES(IV),
    .SYNC_BYTE      (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .counters   (counters),
    .prof_enable(prof_enable),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .seq_num    (seq_num),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: time since enable, a queue holding the frame still to go
  bit        m_on = 1'b0;
  bit        m_en = 1'b0;
  bit        m_busy = 1'b0;
  bit        m_cap = 1'b0;
  bit        m_valid = 1'b0;
  bit        m_ovr = 1'b0;
  int        m_tick = 0;
  int        m_sent = 0;
  bit [7:0]  m_seq = 8'd0;
  bit [7:0]  fq[$];
  bit        m_exp;
  bit        m_hs;
  bit [7:0]  m_sum;
  bit [31:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 1'b0; m_en = 1'b0; m_busy = 1'b0; m_cap = 1'b0;
      m_valid = 1'b0; m_ovr = 1'b0; m_tick = 0; m_sent = 0; m_seq = 8'd0;
      fq.delete();
    end else begin
      m_hs = m_valid && (tx_ready === 1'b1);
      if (!m_on) begin
        if (run) begin
          m_on = 1'b1;
          m_tick = 0;
        end
      end else begin
        m_exp  = (m_tick == IV - 1);
        m_tick = m_exp ? 0 : m_tick + 1;
        if (m_busy) begin
          if (m_exp) m_ovr = 1'b1;
          if (m_cap) begin
            m_cap = 1'b0;
            m_valid = 1'b1;
          end else if (m_hs) begin
            void'(fq.pop_front());
            m_sent++;
            if (fq.size() == 0) begin
              m_valid = 1'b0;
              m_busy = 1'b0;
              if (!run) m_on = 1'b0;
            end
          end
        end else if (!run) begin
          m_on = 1'b0;
        end else if (m_exp) begin
          m_seq = m_seq + 8'd1;
          fq.delete();
          fq.push_back(SYNC);
          fq.push_back(m_seq);
          m_sum = m_seq;
          for (int k = 0; k < N; k++) begin
            m_word = counters[32*k +: 32];
            for (int b = 3; b >= 0; b--) begin
              fq.push_back(m_word[8*b +: 8]);
              m_sum = m_sum + m_word[8*b +: 8];
            end
          end
          fq.push_back(m_sum);
          m_busy = 1'b1;
          m_cap = 1'b1;
          m_sent = 0;
        end
      end
      m_en = run;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("prof_enable", 32'(prof_enable), 32'(m_en));
    chk("tx_valid", 32'(tx_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("seq_num", 32'(seq_num), 32'(m_seq));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (m_valid && fq.size() > 0) chk("tx_data", 32'(tx_data), 32'(fq[0]));
  endtask

  // One clock: drive auto inputs, log the pending handshake, then check
  task automatic cycle();
    if (rand_cnt) begin
      for (int k = 0; k < N; k++) counters[32*k +: 32] = $urandom;
    end
    case (rdy_mode)
      1: tx_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      2: tx_ready = ($urandom_range(0, 1) == 1);
      default: ;
    endcase
    phase++;
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_busy(input bit lvl, input int budget, input string tag);
    int n = 0;
    while (m_busy != lvl && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(m_busy), 32'(lvl));
  endtask

  task automatic wait_sent(input int k, input int budget, input string tag);
    int n = 0;
    while (!(m_busy && m_sent >= k) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(m_busy && m_sent >= k), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < N; k++) counters[32*k +: 32] = 32'(k + 1);

    #12;
    chk("rst_prof_enable", 32'(prof_enable), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq_num", 32'(seq_num), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Basic frame with fixed counters 1..8
    rx.delete();
    run = 1'b1;
    wait_busy(1'b1, 3 * IV, "f1_start");
    wait_busy(1'b0, 3 * IV, "f1_end");
    chk("f1_len", 32'(rx.size()), FLEN);
    if (rx.size() == FLEN) begin
      chk("f1_sync", 32'(rx[0]), 32'hA5);
      chk("f1_seq", 32'(rx[1]), 32'h01);
      chk("f1_c0_msb", 32'(rx[2]), 32'h00);
      chk("f1_c0_lsb", 32'(rx[5]), 32'h01);
      chk("f1_c7_lsb", 32'(rx[33]), 32'h08);
      chk("f1_csum", 32'(rx[34]), 32'h25);
    end

    // Counters change every cycle; frames must carry capture-edge values
    rand_cnt = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_busy(1'b1, 3 * IV, "atom_start");
      wait_busy(1'b0, 3 * IV, "atom_end");
    end
    rand_cnt = 1'b0;

    // Stop mid-frame at byte 10
    wait_sent(10, 3 * IV, "stop_reach");
    run = 1'b0;
    cycle();
    chk("stop_prof_enable", 32'(prof_enable), 32'd0);
    wait_busy(1'b0, 3 * IV, "stop_end");
    repeat (2 * IV) cycle();
    chk("stop_idle_valid", 32'(tx_valid), 32'd0);
    chk("stop_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset at byte 5
    run = 1'b1;
    wait_sent(5, 3 * IV, "arst_reach");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_seq_num", 32'(seq_num), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_prof_enable", 32'(prof_enable), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy(1'b1, 3 * IV, "post_rst_start");
    chk("post_rst_seq", 32'(seq_num), 32'd1);
    wait_busy(1'b0, 3 * IV, "post_rst_end");

    // Overrun: stall 50 cycles mid-frame, skipped interval, next seq = 3
    wait_sent(3, 3 * IV, "ovr_reach");
    tx_ready = 1'b0;
    repeat (50) cycle();
    chk("ovr_set", 32'(overrun), 32'd1);
    tx_ready = 1'b1;
    wait_busy(1'b0, 3 * IV, "ovr_end");
    wait_busy(1'b1, 3 * IV, "ovr_next_start");
    chk("ovr_next_seq", 32'(seq_num), 32'd3);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    wait_busy(1'b0, 3 * IV, "ovr_next_end");

    // Backpressure: 1-0-0-1 pattern, then random ready
    for (int mode = 1; mode <= 2; mode++) begin
      rdy_mode = mode;
      phase = 0;
      for (int f = 0; f < 2; f++) begin
        wait_busy(1'b1, 3 * IV, "bp_start");
        rx.delete();
        wait_busy(1'b0, 8 * IV, "bp_end");
        chk("bp_len", 32'(rx.size()), FLEN);
        if (rx.size() == FLEN) chk("bp_sync", 32'(rx[0]), 32'hA5);
      end
    end
    rdy_mode = 0;
    tx_ready = 1'b1;

    run = 1'b0;
    repeat (5) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
